// File: rtl/drr_scheduler.sv
// Deficit-round-robin scheduler: visits one queue per cycle, credits a quantum per
// visit and grants a whole packet whenever the queue's deficit covers its length.
module drr_scheduler #(
    parameter int NUM_QUEUES       = 5,
    parameter int LEN_WIDTH        = 16,
    parameter int QUANTUM          = 1600,
    parameter int DEFICIT_WIDTH    = 18,
    parameter int NUM_QUEUES_WIDTH = $clog2(NUM_QUEUES)
) (
    input  logic                            axi_aclk,
    input  logic                            axi_reset,
    input  logic [NUM_QUEUES-1:0]           req,
    input  logic [NUM_QUEUES*LEN_WIDTH-1:0] pkt_len,
    input  logic                            pkt_done,
    output logic [NUM_QUEUES-1:0]           grant,
    output logic                            grant_valid,
    output logic [NUM_QUEUES_WIDTH-1:0]     cur_queue,
    output logic                            pkt_grant
);

    typedef enum logic {
        SCAN  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [DEFICIT_WIDTH-1:0]    QUANTUM_D = DEFICIT_WIDTH'(QUANTUM);
    localparam logic [NUM_QUEUES_WIDTH-1:0] LAST_Q    = NUM_QUEUES_WIDTH'(NUM_QUEUES - 1);

    function automatic logic [DEFICIT_WIDTH-1:0] sat_add(
        input logic [DEFICIT_WIDTH-1:0] a,
        input logic [DEFICIT_WIDTH-1:0] b
    );
        logic [DEFICIT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DEFICIT_WIDTH] ? {DEFICIT_WIDTH{1'b1}} : sum[DEFICIT_WIDTH-1:0];
    endfunction

    // A zero-length packet still occupies the link, so it is charged one byte.
    function automatic logic [DEFICIT_WIDTH-1:0] eff_len(input logic [LEN_WIDTH-1:0] l);
        return (l == '0) ? DEFICIT_WIDTH'(1)
                         : {{(DEFICIT_WIDTH-LEN_WIDTH){1'b0}}, l};
    endfunction

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [NUM_QUEUES_WIDTH-1:0] r_cur_queue;
    logic [NUM_QUEUES_WIDTH-1:0] w_cur_queue_nxt;
    logic                        r_fresh;
    logic                        w_fresh_nxt;
    logic [NUM_QUEUES-1:0]       r_grant;
    logic [NUM_QUEUES-1:0]       w_grant_nxt;
    logic                        r_grant_valid;
    logic                        w_grant_valid_nxt;
    logic                        r_pkt_grant;
    logic                        w_pkt_grant_nxt;
    logic [DEFICIT_WIDTH-1:0]    r_len_q;
    logic [DEFICIT_WIDTH-1:0]    w_len_q_nxt;
    logic [DEFICIT_WIDTH-1:0]    r_deficit     [NUM_QUEUES];
    logic [DEFICIT_WIDTH-1:0]    w_deficit_nxt [NUM_QUEUES];

    logic [LEN_WIDTH-1:0]        w_len [NUM_QUEUES];
    logic [DEFICIT_WIDTH-1:0]    w_len_cur;
    logic [DEFICIT_WIDTH-1:0]    w_def_cur;
    logic [NUM_QUEUES_WIDTH-1:0] w_next_queue;
    logic [NUM_QUEUES-1:0]       w_onehot;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_len
        assign w_len[g] = pkt_len[g*LEN_WIDTH +: LEN_WIDTH];
    end

    assign w_len_cur    = eff_len(w_len[r_cur_queue]);
    assign w_def_cur    = r_deficit[r_cur_queue];
    assign w_next_queue = (r_cur_queue == LAST_Q) ? '0 : r_cur_queue + 1'b1;
    assign w_onehot     = NUM_QUEUES'(1) << r_cur_queue;

    always_comb begin
        w_state_nxt       = r_state;
        w_cur_queue_nxt   = r_cur_queue;
        w_fresh_nxt       = r_fresh;
        w_grant_nxt       = r_grant;
        w_grant_valid_nxt = r_grant_valid;
        w_pkt_grant_nxt   = 1'b0;
        w_len_q_nxt       = r_len_q;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            w_deficit_nxt[i] = r_deficit[i];
        end

        case (r_state)
            SCAN: begin
                if (!req[r_cur_queue]) begin
                    // An idle queue forfeits any credit it was carrying.
                    w_deficit_nxt[r_cur_queue] = '0;
                    w_cur_queue_nxt            = w_next_queue;
                    w_fresh_nxt                = 1'b1;
                end else if (r_fresh) begin
                    w_deficit_nxt[r_cur_queue] = sat_add(w_def_cur, QUANTUM_D);
                    w_fresh_nxt                = 1'b0;
                end else if (w_def_cur >= w_len_cur) begin
                    w_len_q_nxt       = w_len_cur;
                    w_grant_nxt       = w_onehot;
                    w_grant_valid_nxt = 1'b1;
                    w_pkt_grant_nxt   = 1'b1;
                    w_state_nxt       = GRANT;
                end else begin
                    w_cur_queue_nxt = w_next_queue;
                    w_fresh_nxt     = 1'b1;
                end
            end
            GRANT: begin
                // Return to SCAN without a new quantum so the same queue may send again.
                if (pkt_done) begin
                    w_deficit_nxt[r_cur_queue] = w_def_cur - r_len_q;
                    w_grant_nxt                = '0;
                    w_grant_valid_nxt          = 1'b0;
                    w_fresh_nxt                = 1'b0;
                    w_state_nxt                = SCAN;
                end
            end
            default: begin
                w_state_nxt = SCAN;
            end
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_state       <= SCAN;
            r_cur_queue   <= '0;
            r_fresh       <= 1'b1;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_pkt_grant   <= 1'b0;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                r_deficit[i] <= '0;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_cur_queue   <= w_cur_queue_nxt;
            r_fresh       <= w_fresh_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_pkt_grant   <= w_pkt_grant_nxt;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                r_deficit[i] <= w_deficit_nxt[i];
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        r_len_q <= w_len_q_nxt;
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign cur_queue   = r_cur_queue;
    assign pkt_grant   = r_pkt_grant;

endmodule

// File: tb/tb_drr_scheduler.sv
// Bench for drr_scheduler: two instances (quantum 1600 and 500) checked every cycle
// against a deficit-round-robin reference model, plus directed timing scenarios.
module tb_drr_scheduler;

    localparam int NQ = 5;
    localparam int LW = 16;
    localparam longint DEF_MAX = 262143;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [4:0]  req_a, req_b;
    logic [79:0] len_a, len_b;
    logic        done_a, done_b;
    logic [4:0]  grant_a, grant_b;
    logic        gv_a, gv_b, pg_a, pg_b;
    logic [2:0]  cur_a, cur_b;

    always #5 clk = ~clk;

    drr_scheduler #(.NUM_QUEUES(5), .LEN_WIDTH(16), .QUANTUM(1600), .DEFICIT_WIDTH(18)) u_a (
        .axi_aclk(clk), .axi_reset(rst_a), .req(req_a), .pkt_len(len_a), .pkt_done(done_a),
        .grant(grant_a), .grant_valid(gv_a), .cur_queue(cur_a), .pkt_grant(pg_a));

    drr_scheduler #(.NUM_QUEUES(5), .LEN_WIDTH(16), .QUANTUM(500), .DEFICIT_WIDTH(18)) u_b (
        .axi_aclk(clk), .axi_reset(rst_b), .req(req_b), .pkt_len(len_b), .pkt_done(done_b),
        .grant(grant_b), .grant_valid(gv_b), .cur_queue(cur_b), .pkt_grant(pg_b));

    // Reference model state, index 0 = instance A, 1 = instance B.
    longint md_def [2][NQ];
    longint md_lenq [2];
    int     md_pos [2];
    bit     md_fresh [2];
    bit     md_busy [2];
    bit     md_pulse [2];

    int     n_assert = 0;
    int     n_fail = 0;
    longint bytes_a [NQ];
    int     wait_a = 0;
    int     wait_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int m, input longint quantum, input logic rst,
                              input logic [4:0] rq, input logic [79:0] pl, input logic done);
        int p;
        longint l;
        md_pulse[m] = 1'b0;
        if (rst) begin
            for (int q = 0; q < NQ; q++) md_def[m][q] = 0;
            md_pos[m]   = 0;
            md_fresh[m] = 1'b1;
            md_busy[m]  = 1'b0;
        end else if (md_busy[m]) begin
            if (done) begin
                md_def[m][md_pos[m]] -= md_lenq[m];
                md_busy[m]  = 1'b0;
                md_fresh[m] = 1'b0;
            end
        end else begin
            p = md_pos[m];
            l = longint'(pl[p*LW +: LW]);
            if (l == 0) l = 1;
            if (!rq[p]) begin
                md_def[m][p] = 0;
                md_pos[m]    = (p + 1) % NQ;
                md_fresh[m]  = 1'b1;
            end else if (md_fresh[m]) begin
                md_def[m][p] = (md_def[m][p] + quantum > DEF_MAX) ? DEF_MAX : md_def[m][p] + quantum;
                md_fresh[m]  = 1'b0;
            end else if (md_def[m][p] >= l) begin
                md_lenq[m]  = l;
                md_busy[m]  = 1'b1;
                md_pulse[m] = 1'b1;
            end else begin
                md_pos[m]   = (p + 1) % NQ;
                md_fresh[m] = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] exp_grant(input int m);
        logic [4:0] g;
        g = md_busy[m] ? (5'b00001 << md_pos[m]) : 5'b00000;
        return 32'(g);
    endfunction

    task automatic tick();
        longint l;
        @(posedge clk);
        model_edge(0, 1600, rst_a, req_a, len_a, done_a);
        model_edge(1, 500, rst_b, req_b, len_b, done_b);
        #1;
        chk("A.grant", 32'(grant_a), exp_grant(0));
        chk("A.grant_valid", 32'(gv_a), 32'(md_busy[0]));
        chk("A.cur_queue", 32'(cur_a), 32'(md_pos[0]));
        chk("A.pkt_grant", 32'(pg_a), 32'(md_pulse[0]));
        chk("B.grant", 32'(grant_b), exp_grant(1));
        chk("B.grant_valid", 32'(gv_b), 32'(md_busy[1]));
        chk("B.cur_queue", 32'(cur_b), 32'(md_pos[1]));
        chk("B.pkt_grant", 32'(pg_b), 32'(md_pulse[1]));
        if (pg_a === 1'b1) begin
            for (int q = 0; q < NQ; q++) begin
                if (grant_a[q] === 1'b1) begin
                    l = longint'(len_a[q*LW +: LW]);
                    bytes_a[q] += (l == 0) ? 1 : l;
                end
            end
        end
        done_a = 1'b0;
        done_b = 1'b0;
    endtask

    task automatic auto_done(input int maxwait);
        if (md_busy[0]) begin
            if (wait_a <= 0) begin
                done_a = 1'b1;
                wait_a = int'($urandom_range(0, maxwait));
            end else wait_a--;
        end
        if (md_busy[1]) begin
            if (wait_b <= 0) begin
                done_b = 1'b1;
                wait_b = int'($urandom_range(0, maxwait));
            end else wait_b--;
        end
    endtask

    function automatic logic [15:0] rnd_len();
        case ($urandom_range(0, 7))
            0: return 16'd0;
            1: return 16'd1;
            2: return 16'd64;
            3: return 16'd1500;
            4: return 16'd1600;
            5: return 16'd1601;
            6: return 16'd3000;
            default: return 16'($urandom_range(0, 5000));
        endcase
    endfunction

    task automatic reset_a();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, cyc, run, visits, q1_pkts;
        longint diff;
        rst_a = 1'b1; rst_b = 1'b1;
        req_a = '0; req_b = '0; len_a = '0; len_b = '0;
        done_a = 1'b0; done_b = 1'b0;
        tick();
        tick();
        chk("rst.grant_valid", 32'(gv_a), 32'd0);
        chk("rst.grant", 32'(grant_a), 32'd0);
        chk("rst.cur_queue", 32'(cur_a), 32'd0);
        chk("rst.pkt_grant", 32'(pg_a), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;

        // Idle scan after reset: one queue per cycle, never a grant.
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("idle.cur_queue", 32'(cur_a), 32'(k % NQ));
            chk("idle.grant_valid", 32'(gv_a), 32'd0);
        end

        // Single queue, 64-byte packets: 25 fit in one quantum.
        reset_a();
        req_a = 5'b00001;
        len_a[0 +: LW] = 16'd64;
        tick();
        chk("single.no_grant_yet", 32'(gv_a), 32'd0);
        tick();
        chk("single.grant_valid", 32'(gv_a), 32'd1);
        chk("single.grant", 32'(grant_a), 32'd1);
        chk("single.pkt_grant", 32'(pg_a), 32'd1);
        tick();
        chk("single.pulse_once", 32'(pg_a), 32'd0);
        chk("single.hold", 32'(gv_a), 32'd1);
        for (int i = 2; i <= 25; i++) begin
            done_a = 1'b1;
            tick();
            chk("single.drop", 32'(gv_a), 32'd0);
            tick();
            chk("single.b2b_grant", 32'(gv_a), 32'd1);
            chk("single.b2b_pulse", 32'(pg_a), 32'd1);
        end
        done_a = 1'b1;
        tick();
        tick();
        chk("single.exhausted", 32'(gv_a), 32'd0);
        chk("single.moved_on", 32'(cur_a), 32'd1);
        req_a = '0;

        // Oversize packet on the quantum-500 instance.
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        req_b = 5'b00100;
        len_b[2*LW +: LW] = 16'd1200;
        cnt = 0;
        while (cnt < 40 && gv_b !== 1'b1) begin
            tick();
            cnt++;
        end
        chk("oversize.latency", 32'(cnt), 32'd16);
        chk("oversize.grant", 32'(grant_b), 32'b00100);
        len_b[2*LW +: LW] = 16'd300;
        done_b = 1'b1;
        tick();
        chk("oversize.drop", 32'(gv_b), 32'd0);
        tick();
        chk("oversize.residual_300", 32'(gv_b), 32'd1);
        done_b = 1'b1;
        req_b = '0;
        tick();

        // Grant held while req drops; deficit cleared on the idle visit.
        reset_a();
        req_a = 5'b00001;
        len_a[0 +: LW] = 16'd1000;
        tick();
        tick();
        chk("hold.granted", 32'(gv_a), 32'd1);
        req_a = '0;
        len_a[0 +: LW] = 16'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold.grant_valid", 32'(gv_a), 32'd1);
            chk("hold.grant", 32'(grant_a), 32'd1);
        end
        done_a = 1'b1;
        tick();
        chk("hold.released", 32'(gv_a), 32'd0);
        tick();
        chk("hold.idle_visit", 32'(cur_a), 32'd1);
        req_a = 5'b00001;
        len_a[0 +: LW] = 16'd1700;
        repeat (4) tick();
        chk("hold.back_to_q0", 32'(cur_a), 32'd0);
        tick();
        tick();
        chk("hold.idle_cleared_gv", 32'(gv_a), 32'd0);
        chk("hold.idle_cleared_cur", 32'(cur_a), 32'd1);
        req_a = '0;

        // Mid-packet reset, then a spurious done in SCAN.
        reset_a();
        req_a = 5'b00001;
        len_a[0 +: LW] = 16'd64;
        tick();
        tick();
        chk("midrst.granted", 32'(gv_a), 32'd1);
        rst_a = 1'b1;
        tick();
        chk("midrst.grant_valid", 32'(gv_a), 32'd0);
        chk("midrst.grant", 32'(grant_a), 32'd0);
        chk("midrst.cur_queue", 32'(cur_a), 32'd0);
        rst_a = 1'b0;
        len_a[0 +: LW] = 16'd1600;
        done_a = 1'b1;
        tick();
        chk("spurious.no_grant", 32'(gv_a), 32'd0);
        tick();
        chk("spurious.done_ignored", 32'(gv_a), 32'd1);
        done_a = 1'b1;
        tick();
        tick();
        chk("midrst.deficit_discarded", 32'(gv_a), 32'd0);
        chk("midrst.moved_on", 32'(cur_a), 32'd1);
        req_a = '0;

        // Byte fairness: 1500-byte vs 100-byte packets over 20 rounds.
        reset_a();
        for (int q = 0; q < NQ; q++) bytes_a[q] = 0;
        req_a = 5'b00011;
        len_a[0 +: LW] = 16'd1500;
        len_a[LW +: LW] = 16'd100;
        wait_a = 0;
        cyc = 0; run = 0; visits = 0; q1_pkts = 0;
        while (q1_pkts < 320 && cyc < 6000) begin
            auto_done(2);
            tick();
            cyc++;
            if (pg_a === 1'b1) begin
                if (grant_a[1] === 1'b1) begin
                    q1_pkts++;
                    run++;
                end else begin
                    if (run != 0) begin
                        chk("fair.q1_per_visit", 32'(run), 32'd16);
                        visits++;
                    end
                    run = 0;
                end
            end
        end
        chk("fair.completed", 32'(cyc < 6000), 32'd1);
        chk("fair.last_visit", 32'(run), 32'd16);
        chk("fair.visits", 32'(visits), 32'd19);
        chk("fair.q1_bytes", 32'(bytes_a[1]), 32'd32000);
        diff = bytes_a[0] - bytes_a[1];
        if (diff < 0) diff = -diff;
        chk("fair.within_quantum", 32'(diff <= 1600), 32'd1);
        req_a = '0;
        done_a = 1'b1;
        tick();

        // Randomised traffic on both instances.
        wait_a = 0; wait_b = 0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 9) == 0) req_a = 5'($urandom);
            if ($urandom_range(0, 9) == 0) req_b = 5'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                int q;
                q = int'($urandom_range(0, 4));
                len_a[q*LW +: LW] = rnd_len();
                q = int'($urandom_range(0, 4));
                len_b[q*LW +: LW] = rnd_len();
            end
            auto_done(4);
            if (!md_busy[0] && $urandom_range(0, 19) == 0) done_a = 1'b1;
            if (!md_busy[1] && $urandom_range(0, 19) == 0) done_b = 1'b1;
            rst_a = ($urandom_range(0, 299) == 0);
            rst_b = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst_a = 1'b0;
        rst_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/drr_scheduler.md
Name: drr_scheduler

Overview:
- Deficit-round-robin packet scheduler that decides which of NUM_QUEUES input FIFOs may forward its next complete packet onto the shared AXI-Stream datapath.
- Sits beside the N-to-1 input arbitration mux: it drives the mux select and one-hot read grant, and gives byte-fair sharing in place of plain packet round robin.
- Packet completion is reported back by the mux (last-beat handshake).

Parameters:
- NUM_QUEUES, 5: number of requesters.
- LEN_WIDTH, 16: width of each packet-length field in bytes.
- QUANTUM, 1600: bytes credited to a queue per round visit.
- DEFICIT_WIDTH, 18: width of each deficit counter. Must be greater than LEN_WIDTH.
- NUM_QUEUES_WIDTH, log2(NUM_QUEUES): width of the queue index.

Ports:
- axi_aclk, in, 1: clock. All logic is on the rising edge.
- axi_reset, in, 1: synchronous, active-high reset.
- req, in, NUM_QUEUES: req[i]=1 means queue i holds at least one complete packet at its head.
- pkt_len, in, NUM_QUEUES*LEN_WIDTH: head-packet byte length of queue i at bits [i*LEN_WIDTH +: LEN_WIDTH]. Valid only while req[i]=1.
- pkt_done, in, 1: one-cycle pulse when the granted packet's last beat completes (tvalid & tready & tlast).
- grant, out, NUM_QUEUES: registered one-hot grant. All zeros when grant_valid=0.
- grant_valid, out, 1: registered; a packet transfer is authorised.
- cur_queue, out, NUM_QUEUES_WIDTH: registered index of the queue being visited or granted. Drives the mux select.
- pkt_grant, out, 1: registered one-cycle pulse per grant issued (stats).

Behaviour:
- Reset (synchronous, axi_reset=1 at an edge):
  - state=SCAN, cur_queue=0, fresh=1, all deficits=0.
  - grant=0, grant_valid=0, pkt_grant=0.
  - Applies mid-packet too: grant drops at the reset edge and accumulated deficits are discarded.
- Internal state:
  - deficit[i], DEFICIT_WIDTH bits, unsigned.
  - fresh flag: set means the current visit has not yet received its quantum.
  - len_q: latched length of the granted packet.
- Effective length: pkt_len of 0 is treated as 1.
- State SCAN, one evaluation per cycle on queue p=cur_queue:
  - req[p]=0: deficit[p]<=0; cur_queue<=p+1, wrapping NUM_QUEUES-1 -> 0; fresh<=1.
  - req[p]=1, fresh=1: deficit[p]<=deficit[p]+QUANTUM, saturating at 2^DEFICIT_WIDTH-1; fresh<=0; stay on p.
  - req[p]=1, fresh=0, deficit[p]>=len: len_q<=len; grant<=1<<p; grant_valid<=1; pkt_grant<=1 for one cycle; go to GRANT.
  - req[p]=1, fresh=0, deficit[p]<len: deficit kept; cur_queue<=p+1 with wrap; fresh<=1.
- State GRANT:
  - Hold grant, grant_valid and cur_queue. Changes on req or pkt_len are ignored.
  - On pkt_done: deficit[p]<=deficit[p]-len_q (never underflows); grant<=0; grant_valid<=0; back to SCAN with fresh=0, so the same queue is re-evaluated without a new quantum.
- pkt_done while in SCAN is ignored.
- Latency:
  - Visit queue with req already high: quantum added at edge k, compare at edge k+1, grant_valid high after edge k+1.
  - Each empty queue costs exactly one cycle.
  - After pkt_done at edge m, the next back-to-back grant of the same queue is high after edge m+1 (one SCAN compare).
- Lengths above QUANTUM: deficit accumulates over successive rounds until it covers the packet.
- Deficit is cleared only when the queue is visited with req=0, or on reset.
- Exactly one grant is outstanding at any time. grant is never multi-hot.

Test Plan:
- Reset behaviour: reset, then req=0 for 10 cycles -> grant_valid=0; cur_queue cycles 0,1,2,3,4,0 one step per cycle; all deficits 0.
- Single packet grant: QUANTUM=1600, req=5'b00001, len0=64 -> grant_valid rises 2 cycles after req sampled with grant=00001 and pkt_grant a one-cycle pulse; after pkt_done, deficit0=1536 and the next 64B packet is granted one cycle later, without an added quantum.
- Byte fairness: queues 0 and 1 always requesting, len0=1500, len1=100, QUANTUM=1600, run 20 rounds -> bytes granted per queue within ±1600 of each other; queue 1 gets 16 packets per visit.
- Oversize packet: QUANTUM=500, len2=1200, only req[2] -> grant only after the third quantum (deficit 1500); deficit 300 after pkt_done.
- Grant hold and clear on idle: deassert req[0] during GRANT -> grant held until pkt_done; on the next visit with req[0]=0, deficit0 is cleared to 0.
- Mid-packet reset and spurious done: reset asserted while grant_valid=1 -> grant=0 and state=SCAN at that edge; a pkt_done pulse in SCAN has no effect on deficits.
